// File: rtl/fc_layer_stream.sv
// Streaming fully connected layer: buffers one input vector, then runs N_MAC MAC lanes per pass
// and streams saturated neuron results in ascending order. Define FC_RELU_EN to clamp negatives to 0.
module fc_layer_stream #(
    parameter int BITS_INT = 4,
    parameter int BITS_FRC = 12,
    parameter int WGHT_INT = 6,
    parameter int WGHT_FRC = 10,
    parameter int N_IN     = 784,
    parameter int N_OUT    = 10,
    parameter int N_MAC    = 10,
    localparam int DW      = BITS_INT + BITS_FRC,
    localparam int WW      = WGHT_INT + WGHT_FRC,
    localparam int N_PASS  = (N_OUT + N_MAC - 1) / N_MAC,
    localparam int AW      = (N_PASS * N_IN > 1) ? $clog2(N_PASS * N_IN) : 1,
    localparam int IW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic [AW-1:0]       w_addr,
    input  logic [N_MAC*WW-1:0] w_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [IW-1:0]       out_index,
    output logic                out_last,
    output logic                busy
);

    localparam int P     = DW + WW;
    localparam int ACC_W = P + $clog2(N_IN);
    localparam int CW    = $clog2(N_IN);
    localparam int CCW   = $clog2(N_IN + 2);
    localparam int PW    = (N_PASS > 1) ? $clog2(N_PASS) : 1;
    localparam int LW    = (N_MAC > 1) ? $clog2(N_MAC) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DW-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DW-1)));

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [CCW-1:0]          cc;
    logic [PW-1:0]           pass;
    logic [LW-1:0]           lane;
    logic                    mac_en;

    logic signed [DW-1:0]    buffer [N_IN];
    logic signed [DW-1:0]    buf_q;
    logic signed [ACC_W-1:0] acc [N_MAC];
    logic signed [WW-1:0]    w_lane [N_MAC];
    logic signed [P-1:0]     prod [N_MAC];

    logic                    accept_last;
    logic                    pass_done;
    logic                    enter_compute;
    logic [LW-1:0]           load_lane;
    logic [DW-1:0]           load_data;
    int                      load_idx;

    // Drop the weight fraction (floor), clamp to the output range, then optionally rectify.
    function automatic logic [DW-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        logic [DW-1:0]           r;
        s = a >>> WGHT_FRC;
        if (s > SAT_MAX)
            r = SAT_MAX[DW-1:0];
        else if (s < SAT_MIN)
            r = SAT_MIN[DW-1:0];
        else
            r = s[DW-1:0];
`ifdef FC_RELU_EN
        if (r[DW-1])
            r = '0;
`endif
        return r;
    endfunction

    always_comb begin
        accept_last   = (state == LOAD) && in_valid && (cnt == CW'(N_IN - 1));
        pass_done     = (state == OUTPUT) && out_valid && out_ready && !out_last
                        && (lane == LW'(N_MAC - 1));
        enter_compute = accept_last || pass_done;
    end

    always_comb begin
        for (int j = 0; j < N_MAC; j++) begin
            w_lane[j] = w_data[j*WW +: WW];
            prod[j]   = P'(buf_q) * P'(w_lane[j]);
        end
    end

    // Lane to present next: the current one on the first OUTPUT cycle, else the following one.
    always_comb begin
        load_lane = lane;
        if (out_valid && (lane != LW'(N_MAC - 1)))
            load_lane = lane + 1'b1;
        load_idx  = int'(pass) * N_MAC + int'(load_lane);
        load_data = saturate(acc[load_lane]);
    end

    always_ff @(posedge clk) begin
        if ((state == LOAD) && in_valid)
            buffer[cnt] <= in_data;
    end

    // Buffer read and weight fetch share one cycle of latency, so the MAC runs one cycle behind issue.
    always_ff @(posedge clk) begin
        if ((state == COMPUTE) && (cc < CCW'(N_IN)))
            buf_q <= buffer[cc[CW-1:0]];
        for (int j = 0; j < N_MAC; j++) begin
            if (enter_compute)
                acc[j] <= '0;
            else if (mac_en)
                acc[j] <= acc[j] + ACC_W'(prod[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            cc        <= '0;
            pass      <= '0;
            lane      <= '0;
            mac_en    <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            w_addr    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt == CW'(N_IN - 1)) begin
                            cnt      <= '0;
                            cc       <= '0;
                            pass     <= '0;
                            w_addr   <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= COMPUTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    mac_en <= (cc < CCW'(N_IN));
                    if (cc < CCW'(N_IN - 1))
                        w_addr <= w_addr + 1'b1;
                    if (cc == CCW'(N_IN + 1)) begin
                        lane  <= '0;
                        state <= OUTPUT;
                    end else begin
                        cc <= cc + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            pass      <= '0;
                            state     <= LOAD;
                        end else if (out_valid && (lane == LW'(N_MAC - 1))) begin
                            out_valid <= 1'b0;
                            pass      <= pass + 1'b1;
                            cc        <= '0;
                            w_addr    <= AW'((int'(pass) + 1) * N_IN);
                            state     <= COMPUTE;
                        end else begin
                            lane      <= load_lane;
                            out_valid <= 1'b1;
                            out_data  <= load_data;
                            out_index <= IW'(load_idx);
                            out_last  <= (load_idx == N_OUT - 1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/fc_layer_stream.md
Name: fc_layer_stream

Overview:
Parametrised fully connected layer: buffers one N_IN-element input vector received over a valid/ready stream, then computes N_OUT dot products with external weights. Uses N_MAC parallel MAC lanes over ceil(N_OUT/N_MAC) passes. Results stream out one neuron per beat, in ascending neuron order, with saturation. Sits between the pixel source and the argmax/classifier stage, and can be chained for multi-layer networks.

Parameters:
BITS_INT, 4, integer bits of input/output data (signed two's complement)
BITS_FRC, 12, fractional bits of input/output data
WGHT_INT, 6, integer bits of weights (signed)
WGHT_FRC, 10, fractional bits of weights
N_IN, 784, input vector length
N_OUT, 10, number of neurons
N_MAC, 10, parallel MAC lanes; N_PASS = ceil(N_OUT/N_MAC)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input element valid
in_ready  out  1  block accepts input element
in_data  in  BITS_INT+BITS_FRC  input element
w_addr  out  clog2(N_PASS*N_IN)  weight memory address
w_data  in  N_MAC*(WGHT_INT+WGHT_FRC)  lane j weights in slice j; data valid 1 cycle after w_addr
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  BITS_INT+BITS_FRC  neuron result
out_index  out  clog2(N_OUT)  neuron number of out_data
out_last  out  1  high on result N_OUT-1
busy  out  1  high in any state except LOAD

Behaviour:
- Single clock clk. Reset is synchronous and active-high (port reset).
- Reset values: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, w_addr=0. State goes to LOAD; element and pass counters go to 0.
- Reset mid-operation discards the buffered vector and partial accumulators. No result is emitted until a full new vector has been loaded.
- LOAD: in_ready=1. Each in_valid&in_ready beat writes in_data to buffer[cnt], then cnt++. The beat with cnt==N_IN-1 moves to COMPUTE with pass=0 and in_ready=0 from the next cycle.
- COMPUTE: over N_IN cycles, issue k=0..N_IN-1 with w_addr=pass*N_IN+k and a synchronous buffer read of element k.
  - One cycle later, each lane j accumulates acc[j] += buffer[k]*w_data[j].
  - Accumulators clear on COMPUTE entry.
  - The final accumulate lands N_IN+1 cycles after entry; the state moves to OUTPUT on the following cycle (N_IN+2 cycles in COMPUTE).
- Arithmetic:
  - Product width P = BITS_INT+BITS_FRC+WGHT_INT+WGHT_FRC, signed.
  - Accumulator width = P+clog2(N_IN); no overflow is possible inside the accumulator.
  - Result = acc arithmetically shifted right by WGHT_FRC (floor), then saturated to the signed (BITS_INT+BITS_FRC) range: max 0x7FFF, min 0x8000 at defaults.
- OUTPUT: present lane r=0..N_MAC-1 with out_index=pass*N_MAC+r.
  - Lanes whose neuron index is >= N_OUT are skipped and never presented.
  - A beat completes on out_valid&out_ready. While out_ready=0, out_valid, out_data, out_index and out_last hold stable.
  - After the last lane: if pass<N_PASS-1, then pass++ and return to COMPUTE; otherwise return to LOAD, with in_ready=1 on the cycle after the out_last beat.
- Input beats are never accepted outside LOAD (in_ready=0); in_valid is ignored there.
- Total per-vector latency, last input beat to first out_valid: N_IN+3 cycles.

Optional Feature:
FC_RELU_EN:
- Defined: after saturation, negative results are replaced with 0 (ReLU), so out_data is never negative.
- Undefined: signed saturated results are output unchanged.
- No timing difference either way.

Test Plan:
- Config N_IN=4, N_OUT=3, N_MAC=2. Load 4x 1.0 (0x1000), all weights 1.0 (0x0400) -> 3 beats, index 0,1,2, data 0x4000; out_last on index 2 only; no beat for lane index 3.
- Same config, pixels 3.0 (0x3000), weights 2.0 (0x0800) -> sum 24.0 saturates to 0x7FFF. With weights -2.0 (0xF800) -> 0x8000 without FC_RELU_EN, 0x0000 with it.
- Pixels 1.0, weights -0.5 (0xFE00) -> -2.0 = 0xE000 without FC_RELU_EN; 0x0000 with FC_RELU_EN.
- Random in_valid gaps during load and out_ready low 5 cycles mid-output -> results identical to the no-stall run; outputs stable while stalled; in_ready=0 throughout COMPUTE/OUTPUT.
- Assert reset for 1 cycle during pass 1 of COMPUTE -> next cycle in_ready=1, out_valid=0, busy=0; a new full vector then produces the correct results with no stale data.
- Default config (784/10/10), all-zero pixels -> 10 beats of 0x0000. First out_valid exactly 787 cycles after the last input beat; w_addr sweeps 0..783.
